regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1: 1 = round-robin between requesters, 0 = fixed priority, MEM over ALU.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 The block SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port alu_valid  input  1  ALU writeback request.
REQ-005 The block SHALL have port alu_ready  output  1  ALU request accepted this cycle.
REQ-006 The block SHALL have port alu_rd  input  5  ALU destination register index.
REQ-007 The block SHALL have port alu_data  input  32  ALU result.
REQ-008 The block SHALL have port mem_valid  input  1  load-unit writeback request.
REQ-009 The block SHALL have port mem_ready  output  1  load request accepted this cycle.
REQ-010 The block SHALL have port mem_rd  input  5  load destination register index.
REQ-011 The block SHALL have port mem_data  input  32  load result.
REQ-012 The block SHALL have port iss_valid  input  1  instruction issued; marks iss_rd pending.
REQ-013 The block SHALL have port iss_rd  input  5  issued destination register.
REQ-014 The block SHALL have port rs1  input  5  source-operand hazard query.
REQ-015 The block SHALL have port rs2  input  5  source-operand hazard query.
REQ-016 The block SHALL have port hazard  output  1  rs1 or rs2 has a pending write.
REQ-017 The block SHALL have port busy  output  32  pending-write scoreboard, one bit per register.
REQ-018 The block SHALL have port store_en  output  1  register-array write strobe, registered.
REQ-019 The block SHALL have port store_sel  output  5  register-array write index, registered.
REQ-020 The block SHALL have port store_data  output  32  register-array write data, registered.

Function
REQ-021 Transfer SHALL occur on a requester only when valid and ready are both high on the same rising edge.
REQ-022 At most one of alu_ready and mem_ready SHALL be high in any cycle; each ready is combinational from the valids and the last_grant state.
REQ-023 A ready SHALL be high only while its own valid is high; with neither valid high, both readies are 0 and last_grant holds.
REQ-024 With exactly one valid high, that requester SHALL be granted.
REQ-025 With both valid and RR_EN=1, the requester not equal to last_grant SHALL be granted.
REQ-026 With both valid and RR_EN=0, MEM SHALL always be granted.
REQ-027 last_grant (1 bit: ALU/MEM) SHALL update to the granted requester on every transfer.
REQ-028 A transfer with rd != 0 SHALL, on the next cycle, drive store_en=1, store_sel=rd and store_data=data (latency 1 cycle).
REQ-029 A transfer with rd = 0 SHALL be accepted but SHALL leave store_en=0 the next cycle.
REQ-030 In cycles without a transfer, store_en SHALL be 0, and store_sel and store_data SHALL hold their previous values.
REQ-031 busy[r] SHALL be set on the edge where iss_valid=1 and iss_rd=r, for r != 0.
REQ-032 busy[r] SHALL be cleared on the edge of a transfer with rd=r.
REQ-033 If set and clear target the same r on the same edge, set SHALL win.
REQ-034 Issue to an already-busy register SHALL leave the bit set; there is no pending count.
REQ-035 busy[0] SHALL be constantly 0.
REQ-036 hazard SHALL equal busy[rs1] | busy[rs2], combinationally, with index 0 never hazarding.

Reset
REQ-037 While reset_n=0, the block SHALL hold busy=0, store_en=0, store_sel=0, store_data=0, last_grant=MEM, alu_ready=0 and mem_ready=0, regardless of the valids.
REQ-038 Reset asserted mid-transfer SHALL discard the in-flight write (store_en=0) and clear all scoreboard bits immediately.
REQ-039 On the first cycle after reset release, with both valid and RR_EN=1, ALU SHALL be granted.

Verification
REQ-040 Scenario single write: alu_valid=1, rd=5, data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle store_en=1, sel=5, data=0xDEADBEEF.
REQ-041 Scenario round-robin: RR_EN=1, both valid for 4 cycles after reset, rd 3 and 4 -> grants ALU, MEM, ALU, MEM; store_sel 3, 4, 3, 4.
REQ-042 Scenario fixed priority: RR_EN=0, both valid for 3 cycles -> mem_ready=1 on all 3 cycles and alu_ready=0 throughout.
REQ-043 Scenario scoreboard: iss rd=7, then rs1=7 -> hazard=1; MEM writeback rd=7 -> busy[7]=0 and hazard=0 the next cycle.
REQ-044 Scenario simultaneous: iss_rd=9 and ALU writeback rd=9 on the same edge -> busy[9]=1 after the edge.
REQ-045 Scenario x0 and reset: writeback rd=0 -> ready=1, store_en stays 0; reset_n pulsed low mid-stream -> busy=0 and store_en=0 immediately.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter with pending-write scoreboard.
//
// Two writeback sources, ALU and load unit (MEM), compete for one
// register-array write port. A grant is combinational from the valids and
// the last granted requester. Accepted writes appear on the registered
// store_* port one cycle later. Writes to x0 are accepted and then dropped.
// The scoreboard marks a destination busy at issue and clears it at
// writeback. A set on the same edge as a clear of the same register wins.
//
// Ports
//   clk, reset_n                 sole clock; asynchronous active-low reset
//   alu_valid/ready/rd/data      ALU writeback request and handshake
//   mem_valid/ready/rd/data      load-unit writeback request and handshake
//   iss_valid, iss_rd            issue marker that sets busy[iss_rd]
//   rs1, rs2, hazard             source-operand query against busy
//   busy                         pending-write scoreboard, bit 0 tied low
//   store_en/sel/data            registered register-array write port
//
// Arbitration state
//   last_grant | meaning
//   GNT_ALU    | ALU took the most recent transfer
//   GNT_MEM    | MEM took the most recent transfer (reset value)

module regfile_write_arbiter #(
   parameter int RR_EN = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_data,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   output logic        hazard,
   output logic [31:0] busy,
   output logic        store_en,
   output logic [4:0]  store_sel,
   output logic [31:0] store_data
);

   typedef enum logic {
      GNT_ALU = 1'b0,
      GNT_MEM = 1'b1
   } grant_t;

   grant_t      last_grant;
   grant_t      last_grant_nxt;
   logic        grant_alu;
   logic        grant_mem;
   logic        xfer;
   logic [4:0]  xfer_rd;
   logic [31:0] xfer_data;
   logic [31:1] busy_q;
   logic [31:1] busy_nxt;

   // Readies are gated by reset_n so they read low during reset.
   always_comb begin
      grant_alu      = 1'b0;
      grant_mem      = 1'b0;
      last_grant_nxt = last_grant;
      if (reset_n) begin
         if (alu_valid && mem_valid) begin
            if (RR_EN != 0 && last_grant == GNT_MEM) grant_alu = 1'b1;
            else                                     grant_mem = 1'b1;
         end else begin
            grant_alu = alu_valid;
            grant_mem = mem_valid;
         end
      end
      if (grant_alu)      last_grant_nxt = GNT_ALU;
      else if (grant_mem) last_grant_nxt = GNT_MEM;
   end

   assign alu_ready = grant_alu;
   assign mem_ready = grant_mem;
   assign xfer      = grant_alu | grant_mem;
   assign xfer_rd   = grant_mem ? mem_rd   : alu_rd;
   assign xfer_data = grant_mem ? mem_data : alu_data;

   // Issue set is applied after the writeback clear, so set wins on a tie.
   always_comb begin
      busy_nxt = busy_q;
      for (int r = 1; r < 32; r++) begin
         if (xfer && xfer_rd == 5'(r))        busy_nxt[r] = 1'b0;
         if (iss_valid && iss_rd == 5'(r))    busy_nxt[r] = 1'b1;
      end
   end

   assign busy   = {busy_q, 1'b0};
   assign hazard = busy[rs1] | busy[rs2];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= GNT_MEM;
         busy_q     <= '0;
         store_en   <= 1'b0;
         store_sel  <= '0;
         store_data <= '0;
      end else begin
         last_grant <= last_grant_nxt;
         busy_q     <= busy_nxt;
         store_en   <= xfer && (xfer_rd != 5'd0);
         // x0 writes are dropped, so the write port keeps its last values.
         if (xfer && xfer_rd != 5'd0) begin
            store_sel  <= xfer_rd;
            store_data <= xfer_data;
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

   logic        clk;
   logic        reset_n;
   logic        alu_valid, mem_valid, iss_valid;
   logic [4:0]  alu_rd, mem_rd, iss_rd, rs1, rs2;
   logic [31:0] alu_data, mem_data;

   logic        rr_alu_ready, rr_mem_ready, rr_hazard, rr_store_en;
   logic [31:0] rr_busy, rr_store_data;
   logic [4:0]  rr_store_sel;
   logic        fp_alu_ready, fp_mem_ready, fp_hazard, fp_store_en;
   logic [31:0] fp_busy, fp_store_data;
   logic [4:0]  fp_store_sel;

   int checks   = 0;
   int failures = 0;

   regfile_write_arbiter #(.RR_EN(1)) dut_rr (
      .clk(clk), .reset_n(reset_n),
      .alu_valid(alu_valid), .alu_ready(rr_alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(rr_mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
      .hazard(rr_hazard), .busy(rr_busy),
      .store_en(rr_store_en), .store_sel(rr_store_sel), .store_data(rr_store_data)
   );

   regfile_write_arbiter #(.RR_EN(0)) dut_fp (
      .clk(clk), .reset_n(reset_n),
      .alu_valid(alu_valid), .alu_ready(fp_alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(fp_mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
      .hazard(fp_hazard), .busy(fp_busy),
      .store_en(fp_store_en), .store_sel(fp_store_sel), .store_data(fp_store_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n   = 1'b0;
      alu_valid = 1'b1; mem_valid = 1'b1; iss_valid = 1'b1;
      alu_rd = 5'd3; mem_rd = 5'd4; iss_rd = 5'd6;
      alu_data = 32'hA3A3_A3A3; mem_data = 32'hB4B4_B4B4;
      rs1 = 5'd0; rs2 = 5'd0;

      // Reset holds everything low regardless of the valids.
      step(); step();
      chk("rst_alu_ready", 32'(rr_alu_ready), 32'd0);
      chk("rst_mem_ready", 32'(rr_mem_ready), 32'd0);
      chk("rst_fp_mem_ready", 32'(fp_mem_ready), 32'd0);
      chk("rst_busy", rr_busy, 32'd0);
      chk("rst_store_en", 32'(rr_store_en), 32'd0);
      chk("rst_store_sel", 32'(rr_store_sel), 32'd0);
      chk("rst_store_data", rr_store_data, 32'd0);

      // Round-robin from reset: ALU, MEM, ALU, MEM. Fixed priority: MEM always.
      iss_valid = 1'b0;
      reset_n   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_alu_ready", 32'(rr_alu_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_mem_ready", 32'(rr_mem_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
         if (i < 3) begin
            chk("fp_mem_ready", 32'(fp_mem_ready), 32'd1);
            chk("fp_alu_ready", 32'(fp_alu_ready), 32'd0);
         end
         step();
         chk("rr_store_en", 32'(rr_store_en), 32'd1);
         chk("rr_store_sel", 32'(rr_store_sel), (i % 2 == 0) ? 32'd3 : 32'd4);
         chk("rr_store_data", rr_store_data, (i % 2 == 0) ? 32'hA3A3_A3A3 : 32'hB4B4_B4B4);
         chk("fp_store_sel", 32'(fp_store_sel), 32'd4);
      end

      // Idle cycle: no strobe, write port holds.
      alu_valid = 1'b0; mem_valid = 1'b0;
      #1;
      chk("idle_alu_ready", 32'(rr_alu_ready), 32'd0);
      chk("idle_mem_ready", 32'(rr_mem_ready), 32'd0);
      step();
      chk("idle_store_en", 32'(rr_store_en), 32'd0);
      chk("idle_store_sel", 32'(rr_store_sel), 32'd4);
      chk("idle_store_data", rr_store_data, 32'hB4B4_B4B4);

      // Single ALU write.
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
      #1;
      chk("single_alu_ready", 32'(rr_alu_ready), 32'd1);
      chk("single_mem_ready", 32'(rr_mem_ready), 32'd0);
      step();
      alu_valid = 1'b0;
      chk("single_store_en", 32'(rr_store_en), 32'd1);
      chk("single_store_sel", 32'(rr_store_sel), 32'd5);
      chk("single_store_data", rr_store_data, 32'hDEAD_BEEF);

      // Scoreboard: issue x7, query, then MEM writeback clears it.
      iss_valid = 1'b1; iss_rd = 5'd7;
      step();
      iss_valid = 1'b0;
      chk("sb_busy_set", rr_busy, 32'h0000_0080);
      rs1 = 5'd7; rs2 = 5'd0; #1;
      chk("sb_hazard_rs1", 32'(rr_hazard), 32'd1);
      rs1 = 5'd0; rs2 = 5'd7; #1;
      chk("sb_hazard_rs2", 32'(rr_hazard), 32'd1);
      rs1 = 5'd0; rs2 = 5'd6; #1;
      chk("sb_hazard_none", 32'(rr_hazard), 32'd0);
      rs1 = 5'd7;
      mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h0000_7777;
      #1;
      chk("sb_mem_ready", 32'(rr_mem_ready), 32'd1);
      step();
      mem_valid = 1'b0;
      #1;
      chk("sb_busy_clr", rr_busy, 32'd0);
      chk("sb_hazard_clr", 32'(rr_hazard), 32'd0);
      chk("sb_store_sel", 32'(rr_store_sel), 32'd7);
      chk("sb_store_data", rr_store_data, 32'h0000_7777);

      // Set and clear of x9 on the same edge: set wins.
      iss_valid = 1'b1; iss_rd = 5'd9;
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0009;
      step();
      iss_valid = 1'b0;
      chk("sim_busy9", rr_busy, 32'h0000_0200);
      chk("sim_store_en", 32'(rr_store_en), 32'd1);
      // Plain writeback now clears it; issuing x0 never sets busy[0].
      iss_valid = 1'b1; iss_rd = 5'd0;
      step();
      iss_valid = 1'b0; alu_valid = 1'b0;
      chk("clr_busy9", rr_busy, 32'd0);

      // Write to x0: accepted, no strobe.
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
      #1;
      chk("x0_alu_ready", 32'(rr_alu_ready), 32'd1);
      step();
      alu_valid = 1'b0;
      chk("x0_store_en", 32'(rr_store_en), 32'd0);

      // Reset mid-stream wipes busy and the in-flight strobe immediately.
      iss_valid = 1'b1; iss_rd = 5'd12;
      step();
      iss_valid = 1'b0;
      chk("pre_rst_busy", rr_busy, 32'h0000_1000);
      alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hCAFE_F00D;
      step();
      chk("pre_rst_store_en", 32'(rr_store_en), 32'd1);
      mem_valid = 1'b1; mem_rd = 5'd11;
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", rr_busy, 32'd0);
      chk("mid_rst_store_en", 32'(rr_store_en), 32'd0);
      chk("mid_rst_alu_ready", 32'(rr_alu_ready), 32'd0);
      chk("mid_rst_mem_ready", 32'(rr_mem_ready), 32'd0);
      step();
      reset_n = 1'b1;
      #1;
      // last_grant is back to MEM, so both valid grants ALU first.
      chk("post_rst_alu_ready", 32'(rr_alu_ready), 32'd1);
      chk("post_rst_mem_ready", 32'(rr_mem_ready), 32'd0);
      step();
      alu_valid = 1'b0; mem_valid = 1'b0;
      chk("post_rst_store_sel", 32'(rr_store_sel), 32'd10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
